// File: rtl/kp_pkg.sv
`default_nettype none
//==============================================================================
// Module      : kp_pkg
// Description : Shared types and the 4x4 keypad decode function for the key
//               debouncer (key code, FSM state encoding, row/column decode).
// Revision    : 1.0 - initial release
//==============================================================================
package kp_pkg;

   typedef logic [3:0] key_code_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2,
      RELEASE  = 2'd3
   } kd_state_t;

   typedef struct packed {
      logic      hit;
      key_code_t code;
   } key_decode_t;

   // A hit needs exactly one row low and exactly one column low; the case
   // defaults reject "none low" and "several low" alike.
   function automatic key_decode_t decode_key(input logic [3:0] kpr,
                                              input logic [3:0] kpc);
      key_decode_t res;
      logic [1:0]  row;
      logic [1:0]  col;
      logic        row_ok;
      logic        col_ok;
      row    = 2'd0;
      col    = 2'd0;
      row_ok = 1'b1;
      col_ok = 1'b1;
      case (kpr)
         4'b0111: row = 2'd0;
         4'b1011: row = 2'd1;
         4'b1101: row = 2'd2;
         4'b1110: row = 2'd3;
         default: row_ok = 1'b0;
      endcase
      case (kpc)
         4'b0111: col = 2'd0;
         4'b1011: col = 2'd1;
         4'b1101: col = 2'd2;
         4'b1110: col = 2'd3;
         default: col_ok = 1'b0;
      endcase
      res.hit = row_ok & col_ok;
      case ({row, col})
         4'b00_00: res.code = 4'h1;
         4'b00_01: res.code = 4'h2;
         4'b00_10: res.code = 4'h3;
         4'b00_11: res.code = 4'hA;
         4'b01_00: res.code = 4'h4;
         4'b01_01: res.code = 4'h5;
         4'b01_10: res.code = 4'h6;
         4'b01_11: res.code = 4'hB;
         4'b10_00: res.code = 4'h7;
         4'b10_01: res.code = 4'h8;
         4'b10_10: res.code = 4'h9;
         4'b10_11: res.code = 4'hC;
         4'b11_00: res.code = 4'hE;   // '*'
         4'b11_01: res.code = 4'h0;
         4'b11_10: res.code = 4'hF;   // '#'
         default:  res.code = 4'hD;
      endcase
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/kp_sync.sv
`default_nettype none
//==============================================================================
// Module      : kp_sync
// Description : W-bit two-flop synchronizer / delay line with a parameterised
//               reset value.
// Revision    : 1.0 - initial release
//==============================================================================
module kp_sync #(
   parameter int           W       = 4,
   parameter logic [W-1:0] RST_VAL = '1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;

   // Two back-to-back flops; both load the idle pattern on reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= d;
         r_sync <= r_meta;
      end
   end

   assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/keydebounce.sv
`default_nettype none
//==============================================================================
// Module      : keydebounce
// Description : Decodes one pressed key of a 4x4 keypad from row/column
//               signals, debounces press and release, and emits a one-cycle
//               strobe per accepted press plus a held-valid level.
// Revision    : 1.0 - initial release
//==============================================================================
module keydebounce
   import kp_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] kpr,
   input  logic [3:0] kpc,
   output logic [3:0] key,
   output logic       key_valid,
   output logic       key_stb
);

   localparam int              CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] c_last = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

   logic [3:0]       w_kpr_s;
   logic [3:0]       w_kpc_d;
   key_decode_t      w_dec;

   kd_state_t        r_state;
   kd_state_t        w_state_nxt;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_nxt;
   key_code_t        r_cand;
   key_code_t        w_cand_nxt;
   key_code_t        r_key;
   key_code_t        w_key_nxt;
   logic             r_stb;
   logic             w_stb_nxt;

   // Rows are asynchronous pins; columns come from the sequencer and are
   // delayed by the same two stages so each synced row pairs with its column.
   kp_sync #(.W(4), .RST_VAL(4'b1111)) u_kpr_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (kpr),
      .q       (w_kpr_s)
   );

   kp_sync #(.W(4), .RST_VAL(4'b0111)) u_kpc_delay (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (kpc),
      .q       (w_kpc_d)
   );

   assign w_dec = decode_key(w_kpr_s, w_kpc_d);

   // State register: FSM state, debounce counter, candidate, accepted key, strobe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_count <= '0;
         r_cand  <= 4'h0;
         r_key   <= 4'h0;
         r_stb   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_cand  <= w_cand_nxt;
         r_key   <= w_key_nxt;
         r_stb   <= w_stb_nxt;
      end
   end

   // Next-state logic: a code must be seen DEBOUNCE_CYCLES samples in a row to
   // be accepted, and absent for DEBOUNCE_CYCLES samples to be released.
   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_cand_nxt  = r_cand;
      w_key_nxt   = r_key;
      w_stb_nxt   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_dec.hit) begin
               w_state_nxt = DEBOUNCE;
               w_cand_nxt  = w_dec.code;
               w_count_nxt = c_one;
            end
         end
         DEBOUNCE: begin
            if (w_dec.hit && (w_dec.code == r_cand)) begin
               if (r_count == c_last) begin
                  w_state_nxt = PRESSED;
                  w_key_nxt   = r_cand;
                  w_stb_nxt   = 1'b1;
                  w_count_nxt = '0;
               end else begin
                  w_count_nxt = r_count + c_one;
               end
            end else begin
               w_state_nxt = IDLE;
               w_count_nxt = '0;
            end
         end
         PRESSED: begin
            if (!(w_dec.hit && (w_dec.code == r_key))) begin
               w_state_nxt = RELEASE;
               w_count_nxt = c_one;
            end
         end
         RELEASE: begin
            if (w_dec.hit && (w_dec.code == r_key)) begin
               // Key came back before release settled: no new strobe.
               w_state_nxt = PRESSED;
               w_count_nxt = '0;
            end else if (w_dec.hit) begin
               // A different key must wait for a clean release first.
               w_count_nxt = '0;
            end else if (r_count == c_last) begin
               w_state_nxt = IDLE;
               w_count_nxt = '0;
            end else begin
               w_count_nxt = r_count + c_one;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_count_nxt = '0;
         end
      endcase
   end

   // Outputs are direct decodes of registered state.
   always_comb begin
      key       = r_key;
      key_stb   = r_stb;
      key_valid = (r_state == PRESSED) || (r_state == RELEASE);
   end

endmodule
`default_nettype wire

// File: tb/tb_keydebounce.sv
`default_nettype none
//==============================================================================
// Module      : tb_keydebounce
// Description : Directed self-checking bench for keydebounce with a short
//               debounce window (4 cycles, 6-cycle press/release latency).
// Revision    : 1.0 - initial release
//==============================================================================
module tb_keydebounce;

   localparam int DEBOUNCE_CYCLES = 4;
   localparam int LAT             = DEBOUNCE_CYCLES + 2;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] kpr;
   logic [3:0] kpc;
   logic [3:0] key;
   logic       key_valid;
   logic       key_stb;

   int checks = 0;
   int errors = 0;

   keydebounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .kpr       (kpr),
      .kpc       (kpc),
      .key       (key),
      .key_valid (key_valid),
      .key_stb   (key_stb)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs driven and outputs sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      kpr     = 4'b1111;
      kpc     = 4'b0111;
      repeat (3) step();
      checks++;
      if (key !== 4'h0) begin errors++; $display("FAIL reset_key: got %h expected 0", key); end
      checks++;
      if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
      checks++;
      if (key_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b expected 0", key_stb); end
      reset_n = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         step();
         checks++;
         if (key_stb !== 1'b0 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset cycle %0d: stb=%b valid=%b expected 0/0", i, key_stb, key_valid);
         end
      end
   endtask

   // '8' (row 2, col 1) held; then release and check release latency.
   task automatic test_press_latency();
      kpc = 4'b1011;
      kpr = 4'b1101;
      for (int i = 1; i <= 56; i++) begin
         step();
         checks++;
         if (key_stb !== (i == LAT)) begin
            errors++;
            $display("FAIL press8_stb cycle %0d: got %b expected %b", i, key_stb, (i == LAT));
         end
         checks++;
         if (key_valid !== (i >= LAT)) begin
            errors++;
            $display("FAIL press8_valid cycle %0d: got %b expected %b", i, key_valid, (i >= LAT));
         end
         if (i >= LAT) begin
            checks++;
            if (key !== 4'h8) begin errors++; $display("FAIL press8_key cycle %0d: got %h expected 8", i, key); end
         end
      end
      kpr = 4'b1111;
      for (int i = 1; i <= 10; i++) begin
         step();
         checks++;
         if (key_valid !== (i < LAT) || key_stb !== 1'b0 || key !== 4'h8) begin
            errors++;
            $display("FAIL release8 cycle %0d: valid=%b stb=%b key=%h expected %b/0/8",
                     i, key_valid, key_stb, key, (i < LAT));
         end
      end
   endtask

   // '*' (row 3, col 0) bouncing 2-on/2-off, then steady.
   task automatic test_bounce();
      kpc = 4'b0111;
      for (int i = 0; i < 20; i++) begin
         kpr = ((i % 4) < 2) ? 4'b1110 : 4'b1111;
         step();
         checks++;
         if (key_stb !== 1'b0 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL bounce cycle %0d: stb=%b valid=%b expected 0/0", i, key_stb, key_valid);
         end
      end
      kpr = 4'b1110;
      for (int i = 1; i <= 10; i++) begin
         step();
         checks++;
         if (key_stb !== (i == LAT) || key_valid !== (i >= LAT)) begin
            errors++;
            $display("FAIL bounce_steady cycle %0d: stb=%b valid=%b expected %b/%b",
                     i, key_stb, key_valid, (i == LAT), (i >= LAT));
         end
         if (i >= LAT) begin
            checks++;
            if (key !== 4'hE) begin errors++; $display("FAIL bounce_key cycle %0d: got %h expected e", i, key); end
         end
      end
      kpr = 4'b1111;
      repeat (10) step();
      checks++;
      if (key_valid !== 1'b0) begin errors++; $display("FAIL bounce_release: valid=%b expected 0", key_valid); end
   endtask

   // '5' (row 1, col 1) accepted, short release glitch, then clean release.
   task automatic test_release_glitch();
      kpc = 4'b1011;
      kpr = 4'b1011;
      for (int i = 1; i <= 8; i++) begin
         step();
         checks++;
         if (key_stb !== (i == LAT)) begin
            errors++;
            $display("FAIL press5_stb cycle %0d: got %b expected %b", i, key_stb, (i == LAT));
         end
      end
      checks++;
      if (key !== 4'h5 || key_valid !== 1'b1) begin
         errors++;
         $display("FAIL press5_key: key=%h valid=%b expected 5/1", key, key_valid);
      end
      kpr = 4'b1111;
      step();
      step();
      kpr = 4'b1011;
      for (int i = 1; i <= 10; i++) begin
         step();
         checks++;
         if (key_valid !== 1'b1 || key_stb !== 1'b0) begin
            errors++;
            $display("FAIL glitch cycle %0d: valid=%b stb=%b expected 1/0", i, key_valid, key_stb);
         end
      end
      kpr = 4'b1111;
      for (int i = 1; i <= 10; i++) begin
         step();
         checks++;
         if (key_valid !== (i < LAT) || key_stb !== 1'b0 || key !== 4'h5) begin
            errors++;
            $display("FAIL release5 cycle %0d: valid=%b stb=%b key=%h expected %b/0/5",
                     i, key_valid, key_stb, key, (i < LAT));
         end
      end
   endtask

   task automatic test_two_rows();
      kpc = 4'b1011;
      kpr = 4'b0011;
      for (int i = 1; i <= 20; i++) begin
         step();
         checks++;
         if (key_stb !== 1'b0 || key_valid !== 1'b0 || key !== 4'h5) begin
            errors++;
            $display("FAIL two_rows cycle %0d: stb=%b valid=%b key=%h expected 0/0/5",
                     i, key_stb, key_valid, key);
         end
      end
      kpr = 4'b1111;
      repeat (4) step();
   endtask

   // Press '2' (row 0, col 1) and expect acceptance after the full latency.
   task automatic press2_expect(input string tag);
      kpc = 4'b1011;
      kpr = 4'b0111;
      for (int i = 1; i <= 8; i++) begin
         step();
         checks++;
         if (key_stb !== (i == LAT) || key_valid !== (i >= LAT)) begin
            errors++;
            $display("FAIL %s cycle %0d: stb=%b valid=%b expected %b/%b",
                     tag, i, key_stb, key_valid, (i == LAT), (i >= LAT));
         end
      end
      checks++;
      if (key !== 4'h2) begin errors++; $display("FAIL %s_key: got %h expected 2", tag, key); end
   endtask

   task automatic test_async_reset();
      // Mid-DEBOUNCE: key still holds '5' from earlier and must clear at once.
      kpc = 4'b1011;
      kpr = 4'b0111;
      repeat (4) step();
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (key !== 4'h0 || key_valid !== 1'b0 || key_stb !== 1'b0) begin
         errors++;
         $display("FAIL async_rst_debounce: key=%h valid=%b stb=%b expected 0/0/0", key, key_valid, key_stb);
      end
      kpr = 4'b1111;
      step();
      step();
      reset_n = 1'b1;
      repeat (3) step();
      press2_expect("rearm_after_rst1");
      // Mid-PRESSED.
      step();
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (key !== 4'h0 || key_valid !== 1'b0 || key_stb !== 1'b0) begin
         errors++;
         $display("FAIL async_rst_pressed: key=%h valid=%b stb=%b expected 0/0/0", key, key_valid, key_stb);
      end
      kpr = 4'b1111;
      step();
      step();
      reset_n = 1'b1;
      repeat (3) step();
      press2_expect("rearm_after_rst2");
   endtask

   initial begin
      test_reset();
      test_press_latency();
      test_bounce();
      test_release_glitch();
      test_two_rows();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
